// File: rtl/rvc_fetch_aligner_if.sv
// Fetch-to-decode handshake bundle for the RVC fetch aligner.
// master drives fetch beats, redirects and decode-ready; slave is the aligner.
interface rvc_fetch_aligner_if #(
  parameter int FETCH_W = 32
);
  logic               flush_i;
  logic [31:0]        flush_pc_i;
  logic               fetch_valid_i;
  logic               fetch_ready_o;
  logic [FETCH_W-1:0] fetch_data_i;
  logic               inst_valid_o;
  logic               inst_ready_i;
  logic [31:0]        inst_o;
  logic [31:0]        inst_pc_o;
  logic               inst_comp_o;
  logic               inst_illegal_o;

  modport master (
    output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
    input  fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_comp_o, inst_illegal_o
  );

  modport slave (
    input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
    output fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_comp_o, inst_illegal_o
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// Halfword queue between fetch and decode: realigns 16/32-bit instructions across
// beat boundaries and expands RV32C encodings into their 32-bit equivalents.
module rvc_fetch_aligner #(
  parameter int          FETCH_W   = 32,
  parameter int          QDEPTH_HW = 8,
  parameter bit          RVC_EN    = 1'b1,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  rvc_fetch_aligner_if.slave   bus
);
  localparam int NHW = FETCH_W / 16;
  localparam int PW  = $clog2(QDEPTH_HW);
  localparam int CW  = PW + 1;
  localparam int SKW = $clog2(NHW);

  typedef struct packed {
    logic [31:0] inst;
    logic        illegal;
  } exp_t;

  logic [QDEPTH_HW-1:0][15:0] q;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              count;
  logic [31:0]                head_pc;
  logic [SKW-1:0]             skip;

  logic [NHW-1:0][15:0]       beat_hw;
  logic [NHW-1:0][PW-1:0]     wr_idx;
  logic [15:0]                hw0, hw1;
  logic                       comp, inst_valid, fetch_ready, push, pop, ill;
  logic [CW-1:0]              need, push_n;
  logic [31:0]                inst;
  exp_t                       ex;

  function automatic exp_t expand(input logic [15:0] h);
    exp_t        r;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, nz16;
    logic [9:0]  nzuimm;
    logic [6:0]  uimm7;
    logic [7:0]  uimm8, suimm8;
    rd     = h[11:7];
    rs2    = h[6:2];
    rdp    = {2'b01, h[4:2]};
    rs1p   = {2'b01, h[9:7]};
    imm6   = {{6{h[12]}}, h[12], h[6:2]};
    nz16   = {{2{h[12]}}, h[12], h[4:3], h[5], h[2], h[6], 4'b0};
    nzuimm = {h[10:7], h[12:11], h[5], h[6], 2'b00};
    uimm7  = {h[5], h[12:10], h[6], 2'b00};
    uimm8  = {h[3:2], h[12], h[6:4], 2'b00};
    suimm8 = {h[8:7], h[12:9], 2'b00};
    r.inst    = 32'h0;
    r.illegal = 1'b0;
    case (h[1:0])
      2'b00: case (h[15:13])
        3'b000: begin
          r.inst    = {2'b00, nzuimm, 5'd2, 3'b000, rdp, 7'h13};
          r.illegal = (nzuimm == 10'd0);
        end
        3'b010:  r.inst = {5'd0, uimm7, rs1p, 3'b010, rdp, 7'h03};
        3'b110:  r.inst = {5'd0, uimm7[6:5], rdp, rs1p, 3'b010, uimm7[4:0], 7'h23};
        default: r.illegal = 1'b1;
      endcase
      2'b01: case (h[15:13])
        3'b000: r.inst = {imm6, rd, 3'b000, rd, 7'h13};
        3'b001: r.inst = {h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3],
                          h[12], {8{h[12]}}, 5'd1, 7'h6F};
        3'b010: r.inst = {imm6, 5'd0, 3'b000, rd, 7'h13};
        3'b011: begin
          // rd=x2 selects c.addi16sp; every other rd is c.lui
          if (rd == 5'd2) begin
            r.inst    = {nz16, 5'd2, 3'b000, 5'd2, 7'h13};
            r.illegal = (nz16 == 12'd0);
          end else begin
            r.inst    = {{14{h[12]}}, h[12], h[6:2], rd, 7'h37};
            r.illegal = ({h[12], h[6:2]} == 6'd0);
          end
        end
        3'b100: case (h[11:10])
          2'b00: begin
            r.inst    = {6'b000000, h[12], h[6:2], rs1p, 3'b101, rs1p, 7'h13};
            r.illegal = h[12];
          end
          2'b01: begin
            r.inst    = {6'b010000, h[12], h[6:2], rs1p, 3'b101, rs1p, 7'h13};
            r.illegal = h[12];
          end
          2'b10: r.inst = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            r.illegal = h[12];
            case (h[6:5])
              2'b00:   r.inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
              2'b01:   r.inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
              2'b10:   r.inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
              default: r.inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
            endcase
          end
        endcase
        3'b101: r.inst = {h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3],
                          h[12], {8{h[12]}}, 5'd0, 7'h6F};
        3'b110: r.inst = {h[12], {3{h[12]}}, h[6:5], h[2], 5'd0, rs1p, 3'b000,
                          h[11:10], h[4:3], h[12], 7'h63};
        default: r.inst = {h[12], {3{h[12]}}, h[6:5], h[2], 5'd0, rs1p, 3'b001,
                           h[11:10], h[4:3], h[12], 7'h63};
      endcase
      2'b10: case (h[15:13])
        3'b000: begin
          r.inst    = {6'b000000, h[12], h[6:2], rd, 3'b001, rd, 7'h13};
          r.illegal = h[12];
        end
        3'b010: begin
          r.inst    = {4'd0, uimm8, 5'd2, 3'b010, rd, 7'h03};
          r.illegal = (rd == 5'd0);
        end
        3'b100: begin
          if (!h[12]) begin
            if (rs2 == 5'd0) begin
              r.inst    = {12'd0, rd, 3'b000, 5'd0, 7'h67};
              r.illegal = (rd == 5'd0);
            end else begin
              r.inst = {7'd0, rs2, 5'd0, 3'b000, rd, 7'h33};
            end
          end else if (rs2 == 5'd0) begin
            r.inst = (rd == 5'd0) ? 32'h0010_0073 : {12'd0, rd, 3'b000, 5'd1, 7'h67};
          end else begin
            r.inst = {7'd0, rs2, rd, 3'b000, rd, 7'h33};
          end
        end
        3'b110:  r.inst = {4'd0, suimm8[7:5], rs2, 5'd2, 3'b010, suimm8[4:0], 7'h23};
        default: r.illegal = 1'b1;
      endcase
      default: r.illegal = 1'b1;
    endcase
    if (r.illegal) r.inst = {16'h0, h};
    return r;
  endfunction

  assign beat_hw     = bus.fetch_data_i;
  assign hw0         = q[rd_ptr];
  assign hw1         = q[rd_ptr + PW'(1)];
  assign comp        = RVC_EN && (hw0[1:0] != 2'b11);
  assign need        = comp ? CW'(1) : CW'(2);
  assign inst_valid  = (count >= need) && !bus.flush_i;
  assign fetch_ready = (CW'(QDEPTH_HW) - count) >= CW'(NHW);
  assign push        = bus.fetch_valid_i && fetch_ready && !bus.flush_i;
  assign pop         = inst_valid && bus.inst_ready_i;
  assign push_n      = CW'(NHW) - CW'(skip);

  always_comb begin
    for (int i = 0; i < NHW; i++) wr_idx[i] = wr_ptr + PW'(i) - PW'(skip);
  end

  always_comb begin
    ex   = expand(hw0);
    inst = {hw1, hw0};
    ill  = 1'b0;
    if (comp) begin
      inst = ex.inst;
      ill  = ex.illegal;
    end else if (hw0[1:0] != 2'b11) begin
      inst = {16'h0, hw0};
      ill  = 1'b1;
    end
  end

  assign bus.fetch_ready_o  = fetch_ready;
  assign bus.inst_valid_o   = inst_valid;
  assign bus.inst_o         = inst;
  assign bus.inst_pc_o      = head_pc;
  // flags only mean something with a valid head; keep them quiet otherwise
  assign bus.inst_comp_o    = inst_valid && comp;
  assign bus.inst_illegal_o = inst_valid && ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= RESET_PC;
      skip    <= RESET_PC[SKW:1];
    end else if (bus.flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= bus.flush_pc_i & 32'hFFFF_FFFE;
      skip    <= bus.flush_pc_i[SKW:1];
    end else begin
      // leading `skip` halfwords of the first beat after entry precede the target PC
      if (push) begin
        for (int i = 0; i < NHW; i++)
          if (i >= int'(skip)) q[wr_idx[i]] <= beat_hw[i];
        wr_ptr <= wr_ptr + PW'(push_n);
        skip   <= '0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(need);
        head_pc <= head_pc + (comp ? 32'd2 : 32'd4);
      end
      count <= count + (push ? push_n : CW'(0)) - (pop ? need : CW'(0));
    end
  end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboard bench for rvc_fetch_aligner: expected issues queued at stimulus time,
// retired by a handshake monitor; scenario tasks add inline flow-control checks.
module tb_rvc_fetch_aligner;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  rvc_fetch_aligner_if #(.FETCH_W(32)) bus ();
  rvc_fetch_aligner_if #(.FETCH_W(32)) bus0 ();

  rvc_fetch_aligner #(.FETCH_W(32), .QDEPTH_HW(8), .RVC_EN(1'b1), .RESET_PC(32'h0))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  rvc_fetch_aligner #(.FETCH_W(32), .QDEPTH_HW(8), .RVC_EN(1'b0), .RESET_PC(32'h0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.inst_valid_o && bus.inst_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue got inst=%h pc=%h", bus.inst_o, bus.inst_pc_o);
      end else begin
        mon_e = sb.pop_front();
        if (bus.inst_o !== mon_e.inst || bus.inst_pc_o !== mon_e.pc ||
            bus.inst_comp_o !== mon_e.comp || bus.inst_illegal_o !== mon_e.ill) begin
          errors++;
          $display("FAIL issue got inst=%h pc=%h comp=%b ill=%b want inst=%h pc=%h comp=%b ill=%b",
                   bus.inst_o, bus.inst_pc_o, bus.inst_comp_o, bus.inst_illegal_o,
                   mon_e.inst, mon_e.pc, mon_e.comp, mon_e.ill);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc,
                          input logic comp, input logic ill);
    exp_t e;
    e.inst = inst; e.pc = pc; e.comp = comp; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit acc = 0;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_data_i  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.fetch_ready_o) begin acc = 1; break; end
    end
    tick();
    bus.fetch_valid_i = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL beat_accept got ready=0 want 1 data=%h", d); end
  endtask

  task automatic flush(input logic [31:0] pc);
    bus.flush_i = 1'b1; bus.flush_pc_i = pc;
    tick();
    bus.flush_i = 1'b0;
  endtask

  task automatic wait_drain();
    bus.inst_ready_i = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.inst_valid_o); end
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.fetch_ready_o); end
    checks++; if (bus.inst_comp_o !== 1'b0) begin errors++; $display("FAIL rst_comp got %b want 0", bus.inst_comp_o); end
    checks++; if (bus.inst_illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", bus.inst_illegal_o); end
    checks++; if (bus.inst_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.inst_pc_o); end
    checks++; if (bus0.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b want 1", bus0.fetch_ready_o); end
    rst = 1'b0;
    tick();
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b want 0", bus.inst_valid_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] w [4];
    w = '{32'h00A00093, 32'h00100113, 32'h00200193, 32'h00300213};
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(w[i], 32'(4 * i), 1'b0, 1'b0);
    send_beat(w[0]);
    checks++; if (bus.inst_valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", bus.inst_valid_o); end
    for (int i = 1; i < 4; i++) send_beat(w[i]);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL seq_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_compressed();
    flush(32'h0);
    push_exp(32'h00150513, 32'h0, 1'b1, 1'b0);
    push_exp(32'h00100513, 32'h2, 1'b1, 1'b0);
    send_beat(32'h4505_0505);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL comp_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_straddle();
    flush(32'h0);
    bus.inst_ready_i = 1'b1;
    push_exp(32'h00000013, 32'h0, 1'b1, 1'b0);
    push_exp(32'h00A00093, 32'h2, 1'b0, 1'b0);
    push_exp(32'h00000013, 32'h6, 1'b1, 1'b0);
    send_beat(32'h0093_0001);
    tick();
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL half_filled_valid got %b want 0", bus.inst_valid_o); end
    send_beat(32'h0001_00A0);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL straddle_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_expand();
    logic [15:0] hw [8];
    logic [31:0] ex [8];
    logic        il [8];
    hw = '{16'h6141, 16'h6505, 16'h852E, 16'h8002, 16'h1086, 16'h8C05, 16'h40C0, 16'hA021};
    ex = '{32'h01010113, 32'h00001537, 32'h00B00533, 32'h00008002,
           32'h00001086, 32'h40940433, 32'h0044A403, 32'h0080006F};
    il = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    flush(32'h0);
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(ex[i], 32'(2 * i), 1'b1, il[i]);
    for (int b = 0; b < 4; b++) send_beat({hw[2*b+1], hw[2*b]});
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL expand_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    flush(32'h0);
    bus.inst_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_exp((32'(k) << 20) | 32'h93, 32'(4 * (k - 1)), 1'b0, 1'b0);
      send_beat((32'(k) << 20) | 32'h93);
      if (k == 3) begin
        checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL ready_at_6 got %b want 1", bus.fetch_ready_o); end
      end
    end
    checks++; if (bus.fetch_ready_o !== 1'b0) begin errors++; $display("FAIL ready_at_8 got %b want 0", bus.fetch_ready_o); end
    bus.inst_ready_i = 1'b1;
    tick();
    push_exp(32'h00500093, 32'h10, 1'b0, 1'b0);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_data_i  = 32'h00500093;
    @(negedge clk);
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL ready_before_pushpop got %b want 1", bus.fetch_ready_o); end
    tick();
    bus.fetch_valid_i = 1'b0;
    bus.inst_ready_i  = 1'b0;
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_pushpop got %b want 1", bus.fetch_ready_o); end
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL backpressure_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_flush();
    flush(32'h2);
    bus.inst_ready_i = 1'b0;
    send_beat(32'h0001_0001);
    send_beat(32'h0001_0001);
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h102;
    bus.fetch_valid_i = 1'b1; bus.fetch_data_i = 32'h0001_0001;
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b want 0", bus.inst_valid_o); end
    tick();
    bus.flush_i = 1'b0; bus.fetch_valid_i = 1'b0;
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL post_flush_valid got %b want 0", bus.inst_valid_o); end
    push_exp(32'h00100513, 32'h102, 1'b1, 1'b0);
    push_exp(32'h00A00093, 32'h104, 1'b0, 1'b0);
    send_beat(32'h4505_FFFF);
    send_beat(32'h00A0_0093);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL flush_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_illegal();
    flush(32'h0);
    push_exp(32'h00000000, 32'h0, 1'b1, 1'b1);
    push_exp(32'h00006101, 32'h2, 1'b1, 1'b1);
    send_beat(32'h6101_0000);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL illegal_drain got %0d pending want 0", sb.size()); end
    bus0.inst_ready_i = 1'b0;
    bus0.fetch_valid_i = 1'b1;
    bus0.fetch_data_i  = 32'h4505_4505;
    tick();
    bus0.fetch_valid_i = 1'b0;
    checks++; if (bus0.inst_valid_o !== 1'b1) begin errors++; $display("FAIL norvc_valid got %b want 1", bus0.inst_valid_o); end
    checks++; if (bus0.inst_illegal_o !== 1'b1) begin errors++; $display("FAIL norvc_illegal got %b want 1", bus0.inst_illegal_o); end
    checks++; if (bus0.inst_o !== 32'h00004505) begin errors++; $display("FAIL norvc_inst got %h want 00004505", bus0.inst_o); end
    checks++; if (bus0.inst_comp_o !== 1'b0) begin errors++; $display("FAIL norvc_comp got %b want 0", bus0.inst_comp_o); end
  endtask

  task automatic test_reset_mid();
    flush(32'h40);
    bus.inst_ready_i = 1'b1;
    push_exp(32'h00000013, 32'h40, 1'b1, 1'b0);
    send_beat(32'h0093_0001);
    tick();
    bus.inst_ready_i = 1'b0;
    send_beat(32'h0001_00A0);
    checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h42) begin
      errors++; $display("FAIL pre_rst_head got valid=%b pc=%h want 1 00000042", bus.inst_valid_o, bus.inst_pc_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", bus.inst_valid_o); end
    checks++; if (bus.inst_pc_o !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h want 0", bus.inst_pc_o); end
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %b want 1", bus.fetch_ready_o); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_mid_valid got %b want 0", bus.inst_valid_o); end
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.flush_pc_i = '0; bus.fetch_valid_i = 1'b0;
    bus.fetch_data_i = '0; bus.inst_ready_i = 1'b0;
    bus0.flush_i = 1'b0; bus0.flush_pc_i = '0; bus0.fetch_valid_i = 1'b0;
    bus0.fetch_data_i = '0; bus0.inst_ready_i = 1'b0;
    test_reset();
    test_sequential();
    test_compressed();
    test_straddle();
    test_expand();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_scoreboard got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
